// File: rtl/flash_op_arb.sv
// Two-requester flash operation arbiter: host reads and controller read/program/erase
// share one flash command port, with round-robin arbitration and an ack timeout.
module flash_op_arb #(
   parameter int AddrW         = 16,
   parameter int DataWidth     = 32,
   parameter int TimeoutCycles = 4096
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   // host read port
   input  logic                 host_req_i,
   input  logic [AddrW-1:0]     host_addr_i,
   input  logic                 host_part_i,
   output logic                 host_gnt_o,
   output logic                 host_rvalid_o,
   output logic [DataWidth-1:0] host_rdata_o,
   output logic                 host_rerr_o,
   // controller port
   input  logic                 ctrl_req_i,
   input  logic [1:0]           ctrl_op_i,
   input  logic [AddrW-1:0]     ctrl_addr_i,
   input  logic                 ctrl_part_i,
   input  logic [DataWidth-1:0] ctrl_wdata_i,
   output logic                 ctrl_gnt_o,
   output logic                 ctrl_done_o,
   output logic [DataWidth-1:0] ctrl_rdata_o,
   output logic                 ctrl_err_o,
   // flash command port
   output logic                 flash_rd_o,
   output logic                 flash_prog_o,
   output logic                 flash_pg_erase_o,
   output logic                 flash_bk_erase_o,
   output logic [AddrW-1:0]     flash_addr_o,
   output logic                 flash_part_o,
   output logic [DataWidth-1:0] flash_prog_data_o,
   input  logic                 flash_ack_i,
   input  logic [DataWidth-1:0] flash_rd_data_i,
   input  logic                 flash_init_busy_i,
   output logic                 busy_o
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;
   typedef enum logic [1:0] {OpRead = 2'd0, OpProg = 2'd1, OpPgErase = 2'd2, OpBkErase = 2'd3} op_e;

   localparam int            CntW   = $clog2(TimeoutCycles + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);

   state_e          state_q;
   logic            src_ctrl_q;   // 1: operation in flight belongs to the controller
   logic            ptr_q;        // 1: controller wins the next tie
   logic [CntW-1:0] cnt_q;

   logic can_grant;
   logic gnt_host;
   logic gnt_ctrl;
   op_e  grant_op;
   logic ack_hit;
   logic timeout_hit;

   // Grants are combinational so a lone request is accepted in the cycle it is seen;
   // reset masks them because state_q is only meaningful after the first reset edge.
   assign can_grant = (state_q == StIdle) && !flash_init_busy_i && !rst_i;
   assign gnt_host  = can_grant && host_req_i && (!ctrl_req_i || !ptr_q);
   assign gnt_ctrl  = can_grant && ctrl_req_i && (!host_req_i ||  ptr_q);
   assign grant_op  = gnt_ctrl ? op_e'(ctrl_op_i) : OpRead;

   assign host_gnt_o = gnt_host;
   assign ctrl_gnt_o = gnt_ctrl;
   assign busy_o     = (state_q != StIdle);

   // Ack wins over a coinciding timeout, so the timeout only fires without ack.
   assign ack_hit     = (state_q == StWait) && flash_ack_i;
   assign timeout_hit = (state_q == StWait) && !flash_ack_i && (cnt_q == CntMax);

   // NOTE: every register here is sequential state, so only non-blocking assignments;
   // pulse outputs get a default of 0 at the top of the clocked branch.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q           <= StIdle;
         src_ctrl_q        <= 1'b0;
         ptr_q             <= 1'b0;
         cnt_q             <= '0;
         host_rvalid_o     <= 1'b0;
         host_rdata_o      <= '0;
         host_rerr_o       <= 1'b0;
         ctrl_done_o       <= 1'b0;
         ctrl_rdata_o      <= '0;
         ctrl_err_o        <= 1'b0;
         flash_rd_o        <= 1'b0;
         flash_prog_o      <= 1'b0;
         flash_pg_erase_o  <= 1'b0;
         flash_bk_erase_o  <= 1'b0;
         flash_addr_o      <= '0;
         flash_part_o      <= 1'b0;
         flash_prog_data_o <= '0;
      end else begin
         host_rvalid_o    <= 1'b0;
         host_rerr_o      <= 1'b0;
         ctrl_done_o      <= 1'b0;
         ctrl_err_o       <= 1'b0;
         flash_rd_o       <= 1'b0;
         flash_prog_o     <= 1'b0;
         flash_pg_erase_o <= 1'b0;
         flash_bk_erase_o <= 1'b0;

         unique case (state_q)
            StIdle: begin
               if (gnt_host || gnt_ctrl) begin
                  state_q           <= StIssue;
                  src_ctrl_q        <= gnt_ctrl;
                  ptr_q             <= gnt_host;
                  flash_addr_o      <= gnt_ctrl ? ctrl_addr_i  : host_addr_i;
                  flash_part_o      <= gnt_ctrl ? ctrl_part_i  : host_part_i;
                  flash_prog_data_o <= gnt_ctrl ? ctrl_wdata_i : '0;
                  // The command is registered here so it is visible during StIssue.
                  flash_rd_o        <= (grant_op == OpRead);
                  flash_prog_o      <= (grant_op == OpProg);
                  flash_pg_erase_o  <= (grant_op == OpPgErase);
                  flash_bk_erase_o  <= (grant_op == OpBkErase);
               end
            end
            StIssue: begin
               state_q <= StWait;
               cnt_q   <= CntW'(1);
            end
            StWait: begin
               if (ack_hit || timeout_hit) begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
                  if (src_ctrl_q) begin
                     ctrl_done_o <= 1'b1;
                     ctrl_err_o  <= timeout_hit;
                     if (ack_hit) ctrl_rdata_o <= flash_rd_data_i;
                  end else begin
                     host_rvalid_o <= 1'b1;
                     host_rerr_o   <= timeout_hit;
                     if (ack_hit) host_rdata_o <= flash_rd_data_i;
                  end
               end else if (cnt_q != CntMax) begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_flash_op_arb.sv
// Directed bench for flash_op_arb: host read, contention, program, timeout,
// init gating and reset abort, with hand-computed expectations.
module tb_flash_op_arb;

   localparam int AddrW     = 16;
   localparam int DataWidth = 32;
   localparam int Timeout   = 8;

   logic                 clk_i = 1'b0;
   logic                 rst_i = 1'b1;
   logic                 host_req_i = 1'b0;
   logic [AddrW-1:0]     host_addr_i = '0;
   logic                 host_part_i = 1'b0;
   logic                 host_gnt_o, host_rvalid_o, host_rerr_o;
   logic [DataWidth-1:0] host_rdata_o;
   logic                 ctrl_req_i = 1'b0;
   logic [1:0]           ctrl_op_i = 2'd0;
   logic [AddrW-1:0]     ctrl_addr_i = '0;
   logic                 ctrl_part_i = 1'b0;
   logic [DataWidth-1:0] ctrl_wdata_i = '0;
   logic                 ctrl_gnt_o, ctrl_done_o, ctrl_err_o;
   logic [DataWidth-1:0] ctrl_rdata_o;
   logic                 flash_rd_o, flash_prog_o, flash_pg_erase_o, flash_bk_erase_o;
   logic [AddrW-1:0]     flash_addr_o;
   logic                 flash_part_o;
   logic [DataWidth-1:0] flash_prog_data_o;
   logic                 flash_ack_i = 1'b0;
   logic [DataWidth-1:0] flash_rd_data_i = '0;
   logic                 flash_init_busy_i = 1'b0;
   logic                 busy_o;

   int errors = 0;
   int checks = 0;

   flash_op_arb #(.AddrW(AddrW), .DataWidth(DataWidth), .TimeoutCycles(Timeout)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .host_req_i(host_req_i), .host_addr_i(host_addr_i), .host_part_i(host_part_i),
      .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
      .host_rerr_o(host_rerr_o),
      .ctrl_req_i(ctrl_req_i), .ctrl_op_i(ctrl_op_i), .ctrl_addr_i(ctrl_addr_i),
      .ctrl_part_i(ctrl_part_i), .ctrl_wdata_i(ctrl_wdata_i), .ctrl_gnt_o(ctrl_gnt_o),
      .ctrl_done_o(ctrl_done_o), .ctrl_rdata_o(ctrl_rdata_o), .ctrl_err_o(ctrl_err_o),
      .flash_rd_o(flash_rd_o), .flash_prog_o(flash_prog_o), .flash_pg_erase_o(flash_pg_erase_o),
      .flash_bk_erase_o(flash_bk_erase_o), .flash_addr_o(flash_addr_o), .flash_part_o(flash_part_o),
      .flash_prog_data_o(flash_prog_data_o), .flash_ack_i(flash_ack_i),
      .flash_rd_data_i(flash_rd_data_i), .flash_init_busy_i(flash_init_busy_i), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Inputs change and outputs are sampled around the falling edge.
   task automatic step();
      @(negedge clk_i);
   endtask

   function automatic logic any_out();
      return |{host_gnt_o, host_rvalid_o, host_rdata_o, host_rerr_o, ctrl_gnt_o, ctrl_done_o,
               ctrl_rdata_o, ctrl_err_o, flash_rd_o, flash_prog_o, flash_pg_erase_o,
               flash_bk_erase_o, flash_addr_o, flash_part_o, flash_prog_data_o, busy_o};
   endfunction

   task automatic test_reset();
      rst_i = 1'b1; host_req_i = 1'b1; ctrl_req_i = 1'b1;
      step(); step(); #1;
      checks++; if (any_out() !== 1'b0) begin errors++; $display("FAIL reset_outputs: some output nonzero, gnt=%b/%b busy=%b", host_gnt_o, ctrl_gnt_o, busy_o); end
      host_req_i = 1'b0; ctrl_req_i = 1'b0; rst_i = 1'b0;
      step();
   endtask

   task automatic test_host_only();
      host_req_i = 1'b1; host_addr_i = 16'h0010; host_part_i = 1'b0; #1;
      checks++; if ({host_gnt_o, ctrl_gnt_o, flash_rd_o} !== 3'b100) begin errors++; $display("FAIL host_gnt: gnt/cgnt/rd=%b expected 100", {host_gnt_o, ctrl_gnt_o, flash_rd_o}); end
      step(); host_req_i = 1'b0; #1;
      checks++; if ({flash_rd_o, flash_prog_o, flash_pg_erase_o, flash_bk_erase_o} !== 4'b1000) begin errors++; $display("FAIL host_cmd: cmd=%b expected 1000", {flash_rd_o, flash_prog_o, flash_pg_erase_o, flash_bk_erase_o}); end
      checks++; if ({flash_addr_o, flash_part_o, busy_o} !== {16'h0010, 1'b0, 1'b1}) begin errors++; $display("FAIL host_addr: addr=%h part=%b busy=%b expected 0010 0 1", flash_addr_o, flash_part_o, busy_o); end
      step();
      checks++; if (flash_rd_o !== 1'b0) begin errors++; $display("FAIL host_rd_pulse: rd=%b expected 0", flash_rd_o); end
      step(); flash_ack_i = 1'b1; flash_rd_data_i = 32'hCAFE0001;
      step(); flash_ack_i = 1'b0; flash_rd_data_i = 32'h0; #1;
      checks++; if ({host_rvalid_o, host_rerr_o, busy_o} !== 3'b100) begin errors++; $display("FAIL host_rvalid: rvalid/rerr/busy=%b expected 100", {host_rvalid_o, host_rerr_o, busy_o}); end
      checks++; if (host_rdata_o !== 32'hCAFE0001) begin errors++; $display("FAIL host_rdata: got %h expected cafe0001", host_rdata_o); end
      step();
      checks++; if ({host_rvalid_o, busy_o, host_rdata_o} !== {2'b00, 32'hCAFE0001}) begin errors++; $display("FAIL host_after: rvalid=%b busy=%b rdata=%h expected 0 0 cafe0001", host_rvalid_o, busy_o, host_rdata_o); end
   endtask

   task automatic test_contention();
      rst_i = 1'b1; step(); rst_i = 1'b0;
      host_req_i = 1'b1; host_addr_i = 16'h0020; ctrl_req_i = 1'b1; ctrl_op_i = 2'd0; ctrl_addr_i = 16'h0200; #1;
      checks++; if ({host_gnt_o, ctrl_gnt_o} !== 2'b10) begin errors++; $display("FAIL cont_first: hgnt/cgnt=%b expected 10", {host_gnt_o, ctrl_gnt_o}); end
      step();
      checks++; if ({host_gnt_o, ctrl_gnt_o, flash_rd_o, flash_addr_o} !== {3'b001, 16'h0020}) begin errors++; $display("FAIL cont_issue1: gnts=%b rd=%b addr=%h expected 00 1 0020", {host_gnt_o, ctrl_gnt_o}, flash_rd_o, flash_addr_o); end
      step(); flash_ack_i = 1'b1; #1;
      checks++; if ({host_gnt_o, ctrl_gnt_o} !== 2'b00) begin errors++; $display("FAIL cont_wait_nognt: gnts=%b expected 00", {host_gnt_o, ctrl_gnt_o}); end
      step(); flash_ack_i = 1'b0; #1;
      checks++; if ({host_rvalid_o, host_gnt_o, ctrl_gnt_o} !== 3'b101) begin errors++; $display("FAIL cont_second: rvalid/hgnt/cgnt=%b expected 101", {host_rvalid_o, host_gnt_o, ctrl_gnt_o}); end
      step();
      checks++; if ({flash_rd_o, flash_addr_o} !== {1'b1, 16'h0200}) begin errors++; $display("FAIL cont_issue2: rd=%b addr=%h expected 1 0200", flash_rd_o, flash_addr_o); end
      step(); flash_ack_i = 1'b1;
      step(); flash_ack_i = 1'b0; #1;
      checks++; if ({ctrl_done_o, host_gnt_o, ctrl_gnt_o} !== 3'b110) begin errors++; $display("FAIL cont_third: done/hgnt/cgnt=%b expected 110", {ctrl_done_o, host_gnt_o, ctrl_gnt_o}); end
      step(); host_req_i = 1'b0; ctrl_req_i = 1'b0;
      step(); flash_ack_i = 1'b1;
      step(); flash_ack_i = 1'b0;
      step();
   endtask

   task automatic test_ctrl_program();
      ctrl_req_i = 1'b1; ctrl_op_i = 2'd1; ctrl_addr_i = 16'h0100; ctrl_part_i = 1'b1; ctrl_wdata_i = 32'h12345678; #1;
      checks++; if ({host_gnt_o, ctrl_gnt_o} !== 2'b01) begin errors++; $display("FAIL prog_gnt: hgnt/cgnt=%b expected 01", {host_gnt_o, ctrl_gnt_o}); end
      step(); ctrl_req_i = 1'b0; #1;
      checks++; if ({flash_rd_o, flash_prog_o, flash_pg_erase_o, flash_bk_erase_o} !== 4'b0100) begin errors++; $display("FAIL prog_cmd: cmd=%b expected 0100", {flash_rd_o, flash_prog_o, flash_pg_erase_o, flash_bk_erase_o}); end
      checks++; if ({flash_addr_o, flash_part_o, flash_prog_data_o} !== {16'h0100, 1'b1, 32'h12345678}) begin errors++; $display("FAIL prog_fields: addr=%h part=%b data=%h expected 0100 1 12345678", flash_addr_o, flash_part_o, flash_prog_data_o); end
      step(); flash_ack_i = 1'b1; flash_rd_data_i = 32'hDEAD0000;
      checks++; if (flash_prog_o !== 1'b0) begin errors++; $display("FAIL prog_pulse: prog=%b expected 0", flash_prog_o); end
      step(); flash_ack_i = 1'b0; flash_rd_data_i = 32'h0; #1;
      checks++; if ({ctrl_done_o, ctrl_err_o, host_rvalid_o, ctrl_rdata_o} !== {3'b100, 32'hDEAD0000}) begin errors++; $display("FAIL prog_done: done/err/rvalid=%b rdata=%h expected 100 dead0000", {ctrl_done_o, ctrl_err_o, host_rvalid_o}, ctrl_rdata_o); end
      step();
      checks++; if ({ctrl_done_o, flash_prog_data_o, flash_addr_o} !== {1'b0, 32'h12345678, 16'h0100}) begin errors++; $display("FAIL prog_hold: done=%b data=%h addr=%h expected 0 12345678 0100", ctrl_done_o, flash_prog_data_o, flash_addr_o); end
   endtask

   task automatic test_timeout();
      ctrl_req_i = 1'b1; ctrl_op_i = 2'd2; ctrl_addr_i = 16'h0042; ctrl_part_i = 1'b0; flash_rd_data_i = 32'h11111111;
      step(); ctrl_req_i = 1'b0; #1;
      checks++; if ({flash_rd_o, flash_prog_o, flash_pg_erase_o, flash_bk_erase_o} !== 4'b0010) begin errors++; $display("FAIL to_cmd: cmd=%b expected 0010", {flash_rd_o, flash_prog_o, flash_pg_erase_o, flash_bk_erase_o}); end
      for (int i = 1; i <= Timeout; i++) begin
         step();
         checks++; if ({ctrl_done_o, busy_o} !== 2'b01) begin errors++; $display("FAIL to_wait%0d: done/busy=%b expected 01", i, {ctrl_done_o, busy_o}); end
      end
      step();
      checks++; if ({ctrl_done_o, ctrl_err_o, busy_o, ctrl_rdata_o} !== {3'b110, 32'hDEAD0000}) begin errors++; $display("FAIL to_done: done/err/busy=%b rdata=%h expected 110 dead0000", {ctrl_done_o, ctrl_err_o, busy_o}, ctrl_rdata_o); end
      step();
      checks++; if ({ctrl_done_o, ctrl_err_o} !== 2'b00) begin errors++; $display("FAIL to_err_pulse: done/err=%b expected 00", {ctrl_done_o, ctrl_err_o}); end
      step(); step(); flash_ack_i = 1'b1;
      step(); flash_ack_i = 1'b0;
      step();
      checks++; if ({ctrl_done_o, ctrl_err_o, host_rvalid_o, busy_o, ctrl_rdata_o} !== {4'b0000, 32'hDEAD0000}) begin errors++; $display("FAIL to_late_ack: done/err/rvalid/busy=%b rdata=%h expected 0000 dead0000", {ctrl_done_o, ctrl_err_o, host_rvalid_o, busy_o}, ctrl_rdata_o); end
   endtask

   task automatic test_init_and_reset();
      flash_init_busy_i = 1'b1; host_req_i = 1'b1; host_addr_i = 16'h0033;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if ({host_gnt_o, busy_o} !== 2'b00) begin errors++; $display("FAIL init_block%0d: gnt/busy=%b expected 00", i, {host_gnt_o, busy_o}); end
         step();
      end
      flash_init_busy_i = 1'b0; #1;
      checks++; if (host_gnt_o !== 1'b1) begin errors++; $display("FAIL init_release: gnt=%b expected 1", host_gnt_o); end
      step(); host_req_i = 1'b0;
      step(); rst_i = 1'b1; flash_ack_i = 1'b1; flash_rd_data_i = 32'h55555555;
      step(); #1;
      checks++; if (any_out() !== 1'b0) begin errors++; $display("FAIL rst_abort: rvalid=%b busy=%b rdata=%h addr=%h expected all 0", host_rvalid_o, busy_o, host_rdata_o, flash_addr_o); end
      rst_i = 1'b0; flash_ack_i = 1'b0;
      step();
      checks++; if ({host_rvalid_o, ctrl_done_o, busy_o} !== 3'b000) begin errors++; $display("FAIL rst_no_pulse: rvalid/done/busy=%b expected 000", {host_rvalid_o, ctrl_done_o, busy_o}); end
      host_req_i = 1'b1; ctrl_req_i = 1'b1; #1;
      checks++; if ({host_gnt_o, ctrl_gnt_o} !== 2'b10) begin errors++; $display("FAIL rst_ptr: hgnt/cgnt=%b expected 10", {host_gnt_o, ctrl_gnt_o}); end
      host_req_i = 1'b0; ctrl_req_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_host_only();
      test_contention();
      test_ctrl_program();
      test_timeout();
      test_init_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
